// File: rtl/sdp_y_core_triosy_pkg.sv
// Shared constants and helpers for the triosy wait array.
package sdp_y_core_triosy_pkg;
   localparam int DEF_NUM_CH = 4;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_CNT_W  = 6;

   // Saturation value of a cnt_w-bit wait counter (cnt_w < 32).
   function automatic logic [31:0] cnt_sat_val(input int cnt_w);
      return (32'd1 << cnt_w) - 32'd1;
   endfunction
endpackage

// File: rtl/sdp_y_core_triosy_wait_array_if.sv
// Bundle of per-channel strobes, payloads and status for the wait array.
interface sdp_y_core_triosy_wait_array_if
   import sdp_y_core_triosy_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
);
   logic [NUM_CH-1:0]             obj_biwt;
   logic [NUM_CH-1:0]             obj_bdwt;
   logic [NUM_CH-1:0][DATA_W-1:0] obj_din;
   logic [NUM_CH-1:0]             err_clr;
   logic [NUM_CH-1:0]             obj_bawt;
   logic [NUM_CH-1:0][DATA_W-1:0] obj_dout;
   logic [NUM_CH-1:0][CNT_W-1:0]  wait_cnt;
   logic [NUM_CH-1:0]             ovr_err;
   logic                          all_bawt;
   logic                          any_err;

   modport master (
      output obj_biwt, obj_bdwt, obj_din, err_clr,
      input  obj_bawt, obj_dout, wait_cnt, ovr_err, all_bawt, any_err
   );
   modport slave (
      input  obj_biwt, obj_bdwt, obj_din, err_clr,
      output obj_bawt, obj_dout, wait_cnt, ovr_err, all_bawt, any_err
   );
endinterface

// File: rtl/sdp_y_core_triosy_wait_ch.sv
// One triosy wait channel: bypass-or-hold payload, held-cycle counter, sticky overrun.
module sdp_y_core_triosy_wait_ch
   import sdp_y_core_triosy_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              nvdla_core_clk,
   input  logic              nvdla_core_rst,
   input  logic              obj_biwt,
   input  logic              obj_bdwt,
   input  logic [DATA_W-1:0] obj_din,
   input  logic              err_clr,
   output logic              obj_bawt,
   output logic [DATA_W-1:0] obj_dout,
   output logic [CNT_W-1:0]  wait_cnt,
   output logic              ovr_err
);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat_val(CNT_W));

   logic              bcwt;
   logic              bcwt_nxt;
   logic              ovr_set;
   logic [DATA_W-1:0] hold_q;

   assign obj_bawt = obj_biwt | bcwt;
   assign obj_dout = bcwt ? hold_q : obj_din;
   assign bcwt_nxt = obj_bawt & ~obj_bdwt;
   assign ovr_set  = obj_biwt & bcwt & ~obj_bdwt;

   // wait_cnt tracks bcwt_nxt so it reads 1 on the first held cycle and
   // drops to 0 together with bcwt on release.
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         bcwt     <= 1'b0;
         hold_q   <= '0;
         wait_cnt <= '0;
         ovr_err  <= 1'b0;
      end else begin
         bcwt <= bcwt_nxt;
         if (obj_biwt && !bcwt)
            hold_q <= obj_din;
         if (!bcwt_nxt)
            wait_cnt <= '0;
         else if (wait_cnt != CNT_MAX)
            wait_cnt <= wait_cnt + 1'b1;
         ovr_err <= ovr_set | (ovr_err & ~err_clr);
      end
   end
endmodule

// File: rtl/sdp_y_core_triosy_wait_array.sv
// Array of independent triosy wait channels plus all-available / any-error reductions.
module sdp_y_core_triosy_wait_array
   import sdp_y_core_triosy_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                              nvdla_core_clk,
   input  logic                              nvdla_core_rst,
   sdp_y_core_triosy_wait_array_if.slave     bus
);
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      sdp_y_core_triosy_wait_ch #(
         .DATA_W (DATA_W),
         .CNT_W  (CNT_W)
      ) u_ch (
         .nvdla_core_clk (nvdla_core_clk),
         .nvdla_core_rst (nvdla_core_rst),
         .obj_biwt       (bus.obj_biwt[gi]),
         .obj_bdwt       (bus.obj_bdwt[gi]),
         .obj_din        (bus.obj_din[gi]),
         .err_clr        (bus.err_clr[gi]),
         .obj_bawt       (bus.obj_bawt[gi]),
         .obj_dout       (bus.obj_dout[gi]),
         .wait_cnt       (bus.wait_cnt[gi]),
         .ovr_err        (bus.ovr_err[gi])
      );
   end

   assign bus.all_bawt = &bus.obj_bawt;
   assign bus.any_err  = |bus.ovr_err;
endmodule

// File: tb/tb_sdp_y_core_triosy_wait_array.sv
// Directed plus randomized check of the wait array against a per-channel behavioural model.
module tb_sdp_y_core_triosy_wait_array;
   localparam int NUM_CH = 4;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 3;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic nvdla_core_clk = 1'b0;
   logic nvdla_core_rst = 1'b1;
   always #5 nvdla_core_clk = ~nvdla_core_clk;

   sdp_y_core_triosy_wait_array_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) ifc ();

   sdp_y_core_triosy_wait_array #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .nvdla_core_clk (nvdla_core_clk),
      .nvdla_core_rst (nvdla_core_rst),
      .bus            (ifc.slave)
   );

   int n_chk = 0;
   int n_err = 0;

   // model: is the channel holding, what it holds, cycles held, sticky error
   bit              m_hold [NUM_CH];
   logic [DATA_W-1:0] m_val [NUM_CH];
   int              m_cnt  [NUM_CH];
   bit              m_err  [NUM_CH];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NUM_CH; i++) begin
         m_hold[i] = 1'b0; m_val[i] = '0; m_cnt[i] = 0; m_err[i] = 1'b0;
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [NUM_CH-1:0]        e_bawt, e_err;
      logic [NUM_CH*DATA_W-1:0] e_dout, din_f;
      logic [NUM_CH*CNT_W-1:0]  e_cnt;
      din_f = ifc.obj_din;
      for (int i = 0; i < NUM_CH; i++) begin
         e_bawt[i] = ifc.obj_biwt[i] | m_hold[i];
         e_dout[i*DATA_W +: DATA_W] = m_hold[i] ? m_val[i] : din_f[i*DATA_W +: DATA_W];
         e_cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
         e_err[i] = m_err[i];
      end
      chk({tag, ".bawt"},     64'(ifc.obj_bawt), 64'(e_bawt));
      chk({tag, ".dout"},     64'(ifc.obj_dout), 64'(e_dout));
      chk({tag, ".wait_cnt"}, 64'(ifc.wait_cnt), 64'(e_cnt));
      chk({tag, ".ovr_err"},  64'(ifc.ovr_err),  64'(e_err));
      chk({tag, ".all_bawt"}, 64'(ifc.all_bawt), 64'(&e_bawt));
      chk({tag, ".any_err"},  64'(ifc.any_err),  64'(|e_err));
   endtask

   task automatic model_clock();
      logic [NUM_CH*DATA_W-1:0] din_f;
      bit bi, bd, nh;
      din_f = ifc.obj_din;
      for (int i = 0; i < NUM_CH; i++) begin
         bi = ifc.obj_biwt[i];
         bd = ifc.obj_bdwt[i];
         nh = (bi || m_hold[i]) && !bd;
         m_err[i] = (m_hold[i] && bi && !bd) || (m_err[i] && !ifc.err_clr[i]);
         if (!m_hold[i] && bi && !bd)
            m_val[i] = din_f[i*DATA_W +: DATA_W];
         m_cnt[i] = nh ? ((m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX) : 0;
         m_hold[i] = nh;
      end
   endtask

   // One clock: drive at negedge, check before the edge, advance the model on it.
   task automatic cycle(input string tag, input logic [NUM_CH-1:0] bi, input logic [NUM_CH-1:0] bd,
                        input logic [NUM_CH*DATA_W-1:0] din, input logic [NUM_CH-1:0] clr);
      @(negedge nvdla_core_clk);
      ifc.obj_biwt = bi;
      ifc.obj_bdwt = bd;
      ifc.obj_din  = din;
      ifc.err_clr  = clr;
      #2;
      check_outputs(tag);
      @(posedge nvdla_core_clk);
      model_clock();
      #1;
   endtask

   task automatic idle_inputs();
      ifc.obj_biwt = '0; ifc.obj_bdwt = '0; ifc.obj_din = '0; ifc.err_clr = '0;
   endtask

   task automatic hold_reset(input int n);
      nvdla_core_rst = 1'b1;
      model_clear();
      repeat (n) begin
         @(negedge nvdla_core_clk);
         #2 check_outputs("in_reset");
      end
      @(negedge nvdla_core_clk);
      nvdla_core_rst = 1'b0;
   endtask

   initial begin
      idle_inputs();
      model_clear();
      // reset then idle
      hold_reset(3);
      cycle("idle", '0, '0, '0, '0);

      // ch0 capture and hold, counter 1,2,3, release
      cycle("c0_cap", 4'b0001, '0, 32'h0000_00A5, '0);
      chk("c0_cnt1", 64'(ifc.wait_cnt[0]), 64'd1);
      cycle("c0_h1", '0, '0, 32'h0, '0);
      chk("c0_dout_held", 64'(ifc.obj_dout[0]), 64'hA5);
      cycle("c0_h2", '0, '0, 32'h0, '0);
      chk("c0_cnt3", 64'(ifc.wait_cnt[0]), 64'd3);
      cycle("c0_rel", '0, 4'b0001, 32'h0, '0);
      chk("c0_bawt_off", 64'(ifc.obj_bawt[0]), 64'd0);
      chk("c0_cnt0", 64'(ifc.wait_cnt[0]), 64'd0);

      // ch1 saturation
      cycle("c1_cap", 4'b0010, '0, 32'h0000_3C00, '0);
      for (int k = 0; k < 10; k++) cycle("c1_hold", '0, '0, 32'($urandom), '0);
      chk("c1_sat", 64'(ifc.wait_cnt[1]), 64'(CMAX));
      cycle("c1_rel", '0, 4'b0010, '0, '0);

      // ch2 overrun, clear, set-wins-over-clear
      cycle("c2_cap", 4'b0100, '0, 32'h0011_0000, '0);
      cycle("c2_ovr", 4'b0100, '0, 32'h0022_0000, '0);
      chk("c2_dout_kept", 64'(ifc.obj_dout[2]), 64'h11);
      chk("c2_err_set", 64'(ifc.ovr_err[2]), 64'd1);
      chk("c2_any_err", 64'(ifc.any_err), 64'd1);
      cycle("c2_clr", '0, '0, '0, 4'b0100);
      chk("c2_err_clr", 64'(ifc.ovr_err[2]), 64'd0);
      cycle("c2_setclr", 4'b0100, '0, 32'h0033_0000, 4'b0100);
      chk("c2_set_wins", 64'(ifc.ovr_err[2]), 64'd1);
      cycle("c2_rel", '0, 4'b0100, '0, 4'b0100);
      cycle("c2_idle", '0, '0, '0, '0);

      // all channels pass-through in one cycle
      cycle("all_pass", 4'b1111, 4'b1111, 32'hDEAD_BEEF, '0);
      cycle("all_pass_after", '0, '0, 32'h1234_5678, '0);
      chk("all_pass_bawt", 64'(ifc.obj_bawt), 64'd0);

      // ch3 async reset mid-hold
      cycle("c3_cap", 4'b1000, '0, 32'h5A00_0000, '0);
      cycle("c3_hold", '0, '0, '0, '0);
      #2 nvdla_core_rst = 1'b1;
      #1;
      chk("c3_async_bawt", 64'(ifc.obj_bawt[3]), 64'd0);
      chk("c3_async_cnt", 64'(ifc.wait_cnt[3]), 64'd0);
      chk("c3_async_dout", 64'(ifc.obj_dout[3]), 64'd0);
      hold_reset(2);
      cycle("post_rst", 4'b1000, '0, 32'h7700_0000, '0);
      cycle("post_rst_h", '0, '0, 32'h0100_0000, '0);
      chk("post_rst_dout", 64'(ifc.obj_dout[3]), 64'h77);

      // randomized traffic
      for (int k = 0; k < 600; k++) begin
         logic [NUM_CH-1:0] bi, bd, clr;
         bi  = NUM_CH'($urandom & $urandom);
         bd  = NUM_CH'($urandom & $urandom & $urandom);
         clr = NUM_CH'($urandom & $urandom & $urandom);
         cycle("rand", bi, bd, 32'($urandom), clr);
         if (k == 300) begin
            idle_inputs();
            hold_reset(1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
